ram_req_sequencer: RTL
======================

Name: ram_req_sequencer

Overview:
- Request sequencer sitting directly upstream of the small synchronous RAM (write_en / address / data_in in, data_out out).
- Accepts single read or write requests over a valid/ready handshake and drives the RAM's write strobe, address and write data for exactly the required cycles.
- Waits the RAM's fixed read latency, captures read data and returns one response per request over a second valid/ready handshake.
- Also counts completed transactions.

Parameters:
- ADDR_W, 1, width of the RAM address.
- DATA_W, 4, width of a RAM word.
- RD_LAT, 1, clock edges from address presentation to valid mem_data_out. Legal range 1..15; 0 is illegal.

Ports:
- clk  in  1  single clock, all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  DATA_W  read data; for a write, echoes the written word
- rsp_was_wr  out  1  response belongs to a write
- mem_write_en  out  1  to RAM write_en
- mem_address  out  ADDR_W  to RAM address
- mem_data_in  out  DATA_W  to RAM data_in
- mem_data_out  in  DATA_W  from RAM data_out
- txn_count  out  8  completed responses, wraps 255 -> 0

Behaviour:
- Reset (async, immediate, no clock needed):
  - state = IDLE
  - mem_write_en = 0, mem_address = 0, mem_data_in = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_was_wr = 0, txn_count = 0, wait counter = 0
- req_ready = 1 exactly when state == IDLE, including while rst is high. Requests presented during reset are not accepted.
- States: IDLE, WRITE, READ, RESP.
- Accept at rising edge N when req_valid && req_ready. At that edge:
  - mem_address <= req_addr.
  - Write: mem_data_in <= req_wdata, mem_write_en <= 1, go to WRITE.
  - Read: mem_write_en stays 0, wait counter <= RD_LAT-1, go to READ.
- WRITE:
  - Lasts exactly one cycle, so mem_write_en is high only from edge N to edge N+1 and the RAM samples it at N+1.
  - At N+1: mem_write_en <= 0, rsp_rdata <= mem_data_in, rsp_was_wr <= 1, rsp_valid <= 1, go to RESP.
- READ:
  - mem_address held stable throughout.
  - At each edge with counter != 0, decrement.
  - At the edge with counter == 0 (edge N+RD_LAT): rsp_rdata <= mem_data_out, rsp_was_wr <= 0, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid, rsp_rdata and rsp_was_wr held stable until the edge where rsp_ready == 1.
  - At that edge: rsp_valid <= 0, txn_count <= txn_count + 1 (mod 256), go to IDLE.
  - rsp_ready is ignored outside RESP.
- mem_address and mem_data_in keep their last values in IDLE and change only on accept.
- Latency, accept to rsp_valid: write 1 cycle; read RD_LAT cycles.
- Minimum spacing between accepts with rsp_ready tied high: write 3 cycles, read RD_LAT+2 cycles. There is no overlap of requests.
- Reset mid-operation (WRITE, READ or RESP): the transaction is aborted and no response is issued. mem_write_en drops at once, so no partial write strobe extends past reset assertion.
- req_valid dropped before acceptance: no effect. Request fields are sampled only at the accept edge; later changes are ignored.

Test Plan:
- Reset then idle: assert rst mid-cycle -> all outputs 0 immediately, req_ready=1; release, no req_valid -> state unchanged, txn_count=0.
- Write: req_we=1, addr=0, wdata=4'b0100, rsp_ready=1 -> mem_write_en high exactly one cycle with mem_data_in=4'b0100; rsp_valid at accept+1 with rsp_rdata=4'b0100, rsp_was_wr=1; txn_count=1.
- Read-after-write against the RAM model: write 4'b1010 then read addr 0, RD_LAT=1 -> rsp_rdata=4'b1010 one cycle after read accept, rsp_was_wr=0, mem_write_en stays 0 throughout the read.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_rdata stable, req_ready=0, a new req_valid is not accepted; rsp_ready=1 -> one handshake, then req_ready=1 next cycle.
- Reset mid-op: rst asserted in WRITE -> mem_write_en falls immediately, no rsp_valid, txn_count unchanged at 0; RD_LAT=3 read aborted in READ likewise.
- Wrap and latency: RD_LAT=3, 256 back-to-back reads with rsp_ready=1 -> each response 3 cycles after accept, accepts 5 cycles apart, txn_count returns to 0.

Source files
------------

// File: rtl/ram_req_sequencer.sv
// ram_req_sequencer
// Sits in front of a small synchronous RAM. Takes one read or write request
// at a time over a valid/ready handshake, drives the RAM strobe/address/data
// for the cycles the access needs, then returns one response per request.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_we            : 1 = write, 0 = read
//   req_addr/wdata    : request fields, sampled only at the accept edge
//   rsp_valid/ready   : response handshake
//   rsp_rdata         : read data, or the written word for a write
//   rsp_was_wr        : response belongs to a write
//   mem_write_en      : RAM write strobe (one cycle per write)
//   mem_address       : RAM address, held until the next accept
//   mem_data_in       : RAM write data, held until the next accept
//   mem_data_out      : RAM read data, valid RD_LAT edges after the address
//   txn_count         : completed responses, wraps 255 -> 0
//
// RD_LAT must lie in 1..15; the wait counter is 4 bits wide.
module ram_req_sequencer #(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_was_wr,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [7:0]        txn_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int CNT_W = 4;
    // Counter starts at RD_LAT-1 so the capture lands on edge accept+RD_LAT.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    state_t              state_reg,     state_next;
    logic [CNT_W-1:0]    cnt_reg,       cnt_next;
    logic                we_reg,        we_next;
    logic [ADDR_W-1:0]   addr_reg,      addr_next;
    logic [DATA_W-1:0]   wdata_reg,     wdata_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]   rdata_reg,     rdata_next;
    logic                was_wr_reg,    was_wr_next;
    logic [7:0]          txn_reg,       txn_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rdata_reg     <= '0;
            was_wr_reg    <= 1'b0;
            txn_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rsp_valid_reg <= rsp_valid_next;
            rdata_reg     <= rdata_next;
            was_wr_reg    <= was_wr_next;
            txn_reg       <= txn_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rsp_valid_next = rsp_valid_reg;
        rdata_next     = rdata_reg;
        was_wr_next    = was_wr_reg;
        txn_next       = txn_reg;

        case (state_reg)
            IDLE: begin
                // req_ready is exactly (state == IDLE), so req_valid alone
                // qualifies the accept here.
                if (req_valid) begin
                    addr_next = req_addr;
                    if (req_we) begin
                        wdata_next = req_wdata;
                        we_next    = 1'b1;
                        state_next = WRITE;
                    end else begin
                        cnt_next   = CNT_INIT;
                        state_next = READ;
                    end
                end
            end
            WRITE: begin
                // Single-cycle strobe; the RAM samples it on this edge.
                we_next        = 1'b0;
                rdata_next     = wdata_reg;
                was_wr_next    = 1'b1;
                rsp_valid_next = 1'b1;
                state_next     = RESP;
            end
            READ: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    rdata_next     = mem_data_out;
                    was_wr_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    txn_next       = txn_reg + 8'd1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_ready    = (state_reg == IDLE);
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_rdata    = rdata_reg;
    assign rsp_was_wr   = was_wr_reg;
    assign mem_write_en = we_reg;
    assign mem_address  = addr_reg;
    assign mem_data_in  = wdata_reg;
    assign txn_count    = txn_reg;

endmodule
